// File: rtl/stby_rail_ctrl_if.sv
// rtl/stby_rail_ctrl_if.sv - signal bundle between the standby rail controller and its environment
interface stby_rail_ctrl_if;
  logic       stby_req;
  logic       stbyP1v05_pwrgd;
  logic       stbyP1v05_en_n;
  logic       rail_on;
  logic       fault_asw;
  logic [2:0] fsm;

  modport master (
    output stby_req, stbyP1v05_pwrgd,
    input  stbyP1v05_en_n, rail_on, fault_asw, fsm
  );

  modport slave (
    input  stby_req, stbyP1v05_pwrgd,
    output stbyP1v05_en_n, rail_on, fault_asw, fsm
  );
endinterface

// File: rtl/stby_rail_ctrl.sv
// rtl/stby_rail_ctrl.sv - standby 1.05 V rail sequencer with power-good filter and fault latch
// Optional automatic retry out of FAULT is enabled by defining STBY_RAIL_RETRY_EN.
module stby_rail_ctrl #(
  parameter int PGOOD_TIMEOUT = 50000,
  parameter int PGOOD_FILT    = 4,
  parameter int OFF_DLY       = 1000
`ifdef STBY_RAIL_RETRY_EN
  ,
  parameter int RETRY_MAX     = 3
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  stby_rail_ctrl_if.slave rail
);

  localparam int               CNT_TOP      = (PGOOD_TIMEOUT > OFF_DLY) ? PGOOD_TIMEOUT : OFF_DLY;
  localparam int               CNT_W        = $clog2(CNT_TOP) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PGOOD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;
  localparam logic [3:0]       FILT_LEN     = 4'(PGOOD_FILT);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP      = 3'd1,
    ST_ON        = 3'd2,
    ST_DISCHARGE = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             pg_f_q;
  logic [3:0]       filt_cnt_q;
  logic             en_n_q, rail_on_q, fault_q;

`ifdef STBY_RAIL_RETRY_EN
  localparam int               RTY_W     = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(RETRY_MAX);
  logic [RTY_W-1:0] retry_q;
`endif

  // Filter counts synchronized samples that disagree with pg_f; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      pg_f_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      sync1_q <= rail.stbyP1v05_pwrgd;
      sync2_q <= sync1_q;
      if (sync2_q == pg_f_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q + 4'd1 >= FILT_LEN) begin
        pg_f_q     <= sync2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (rail.stby_req) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (!rail.stby_req)            state_d = ST_DISCHARGE;
        else if (pg_f_q)               state_d = ST_ON;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
      end
      ST_ON: begin
        if (!rail.stby_req) state_d = ST_DISCHARGE;
        else if (!pg_f_q)   state_d = ST_FAULT;
      end
      ST_DISCHARGE: begin
        if (cnt_q == OFF_LAST) state_d = ST_OFF;
      end
      ST_FAULT: begin
        // Counter saturates, so >= keeps the exit open for as long as FAULT is held.
        if (cnt_q >= OFF_LAST) begin
          if (!rail.stby_req) state_d = ST_OFF;
`ifdef STBY_RAIL_RETRY_EN
          else if (retry_q < RETRY_LIM) state_d = ST_RAMP;
`endif
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      en_n_q    <= 1'b1;
      rail_on_q <= 1'b0;
      fault_q   <= 1'b0;
`ifdef STBY_RAIL_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_n_q    <= !((state_q == ST_RAMP) || (state_q == ST_ON));
      rail_on_q <= (state_q == ST_ON);
      fault_q   <= (state_q == ST_FAULT);
`ifdef STBY_RAIL_RETRY_EN
      if ((state_d == ST_OFF) || ((state_d == ST_ON) && (state_q != ST_ON))) begin
        retry_q <= '0;
      end else if ((state_q == ST_FAULT) && (state_d == ST_RAMP)) begin
        retry_q <= retry_q + 1'b1;
      end
`endif
    end
  end

  assign rail.stbyP1v05_en_n = en_n_q;
  assign rail.rail_on        = rail_on_q;
  assign rail.fault_asw      = fault_q;
  assign rail.fsm            = state_q;

endmodule

// File: tb/tb_stby_rail_ctrl.sv
// tb/tb_stby_rail_ctrl.sv - directed plus randomized bench for stby_rail_ctrl against a reference model
module tb_stby_rail_ctrl;

  localparam int TMO   = 20;
  localparam int FILT  = 3;
  localparam int OFFD  = 10;
  localparam int RETRY = 3;

  localparam int S_OFF = 0, S_RAMP = 1, S_ON = 2, S_DIS = 3, S_FAULT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stby_rail_ctrl_if bus ();

  stby_rail_ctrl #(
    .PGOOD_TIMEOUT(TMO),
    .PGOOD_FILT   (FILT),
    .OFF_DLY      (OFFD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rail (bus)
  );

  always #5 clk = ~clk;

  int m_state, m_t, m_retry;
  bit m_pgf;
  bit m_hist[$];
  bit m_en_n, m_rail_on, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = S_OFF;
    m_t       = 0;
    m_retry   = 0;
    m_pgf     = 1'b0;
    m_hist.delete();
    m_en_n    = 1'b1;
    m_rail_on = 1'b0;
    m_fault   = 1'b0;
  endtask

  // One rising edge: outputs show the state held before the edge, decisions use the old pg_f and timer.
  task automatic model_edge(input bit req, input bit pg);
    int nxt;
    bit flip;
    bit s;
    m_en_n    = !((m_state == S_RAMP) || (m_state == S_ON));
    m_rail_on = (m_state == S_ON);
    m_fault   = (m_state == S_FAULT);
    nxt = m_state;
    case (m_state)
      S_OFF:   if (req) nxt = S_RAMP;
      S_RAMP:  if (!req) nxt = S_DIS; else if (m_pgf) nxt = S_ON; else if (m_t == TMO - 1) nxt = S_FAULT;
      S_ON:    if (!req) nxt = S_DIS; else if (!m_pgf) nxt = S_FAULT;
      S_DIS:   if (m_t == OFFD - 1) nxt = S_OFF;
      S_FAULT: if (m_t >= OFFD - 1) begin
        if (!req) nxt = S_OFF;
`ifdef STBY_RAIL_RETRY_EN
        else if (m_retry < RETRY) begin
          nxt = S_RAMP;
          m_retry++;
        end
`endif
      end
      default: nxt = S_OFF;
    endcase
    if ((nxt == S_OFF) || ((nxt == S_ON) && (m_state != S_ON))) m_retry = 0;
    m_t     = (nxt == m_state) ? m_t + 1 : 0;
    m_state = nxt;
    // The filter sees the pwrgd value sampled two edges earlier.
    m_hist.push_front(pg);
    if (m_hist.size() > 32) void'(m_hist.pop_back());
    flip = 1'b1;
    for (int i = 2; i < 2 + FILT; i++) begin
      s = (i < m_hist.size()) ? m_hist[i] : 1'b0;
      if (s == m_pgf) flip = 1'b0;
    end
    if (flip) m_pgf = !m_pgf;
  endtask

  task automatic check_model();
    chk("fsm", 32'(bus.fsm), m_state);
    chk("en_n", 32'(bus.stbyP1v05_en_n), 32'(m_en_n));
    chk("rail_on", 32'(bus.rail_on), 32'(m_rail_on));
    chk("fault_asw", 32'(bus.fault_asw), 32'(m_fault));
  endtask

  task automatic tick(input bit req, input bit pg);
    bus.stby_req        = req;
    bus.stbyP1v05_pwrgd = pg;
    @(posedge clk);
    model_edge(req, pg);
    #1;
    check_model();
  endtask

  task automatic tick_until(input bit req, input bit pg, input int target, input int budget,
                            input string tag, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < budget) begin
      tick(req, pg);
      n++;
      if (32'(bus.fsm) == target) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int n;
    int lat;
    bit req;
    bit pg;
    int hold;

    bus.stby_req        = 1'b0;
    bus.stbyP1v05_pwrgd = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en_n", 32'(bus.stbyP1v05_en_n), 32'd1);
    chk("rst_rail_on", 32'(bus.rail_on), 32'd0);
    chk("rst_fault", 32'(bus.fault_asw), 32'd0);
    chk("rst_fsm", 32'(bus.fsm), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0);

    // Normal power-up and request-to-enable latency
    tick(1'b1, 1'b0);
    chk("req_to_ramp", 32'(bus.fsm), S_RAMP);
    chk("en_n_lag", 32'(bus.stbyP1v05_en_n), 32'd1);
    tick(1'b1, 1'b0);
    chk("en_n_low", 32'(bus.stbyP1v05_en_n), 32'd0);
    repeat (4) tick(1'b1, 1'b0);
    lat = 0;
    n = 0;
    while (bus.rail_on !== 1'b1 && n < 30) begin
      tick(1'b1, 1'b1);
      n++;
    end
    lat = n - 1;
    chk("up_latency", lat, 2 + FILT + 1);
    chk("up_fault", 32'(bus.fault_asw), 32'd0);

    // Glitch rejection in ON
    repeat (2) tick(1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b1);
    chk("glitch2_fsm", 32'(bus.fsm), S_ON);
    chk("glitch2_rail_on", 32'(bus.rail_on), 32'd1);
    repeat (3) tick(1'b1, 1'b0);
    tick_until(1'b1, 1'b0, S_FAULT, 10, "glitch3_fault", n);
`ifndef STBY_RAIL_RETRY_EN
    repeat (15) tick(1'b1, 1'b0);
    chk("sticky_fault", 32'(bus.fault_asw), 32'd1);
    chk("sticky_en_n", 32'(bus.stbyP1v05_en_n), 32'd1);
    tick(1'b0, 1'b0);
    chk("sticky_release", 32'(bus.fsm), S_OFF);
`endif
    repeat (12) tick(1'b0, 1'b0);

    // Power-good timeout
    tick(1'b1, 1'b0);
    tick_until(1'b1, 1'b0, S_FAULT, 40, "timeout_reached", n);
    chk("ramp_cycles", n, TMO);
    tick_until(1'b0, 1'b0, S_OFF, 30, "fault_exit", n);
    chk("fault_cycles", n, OFFD);

    // Power-down with request bounce during DISCHARGE
    tick_until(1'b1, 1'b1, S_ON, 30, "reup", n);
    tick(1'b0, 1'b1);
    chk("dis_enter", 32'(bus.fsm), S_DIS);
    tick(1'b0, 1'b1);
    tick_until(1'b1, 1'b1, S_OFF, 30, "dis_exit", n);
    chk("dis_cycles", n + 1, OFFD);
    tick(1'b1, 1'b1);
    chk("dis_reramp", 32'(bus.fsm), S_RAMP);

    // Request drop and power-good loss seen on the same edge in ON
    tick_until(1'b1, 1'b1, S_ON, 30, "reup2", n);
    n = 0;
    while (m_pgf && n < 20) begin
      tick(1'b1, 1'b0);
      n++;
    end
    tick(1'b0, 1'b0);
    chk("simul_discharge", 32'(bus.fsm), S_DIS);
    repeat (12) tick(1'b0, 1'b0);

    // Reset asserted mid-RAMP
    repeat (7) tick(1'b1, 1'b0);
    chk("ramp7_en_n", 32'(bus.stbyP1v05_en_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_en_n", 32'(bus.stbyP1v05_en_n), 32'd1);
    chk("async_fsm", 32'(bus.fsm), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    chk("post_rst_fsm", 32'(bus.fsm), S_OFF);

    // Randomized traffic against the model
    req  = 1'b0;
    pg   = 1'b0;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) req = !req;
      if (hold == 0) begin
        pg   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 25);
      end else begin
        hold--;
      end
      tick(req, pg);
    end
    repeat (30) tick(1'b0, 1'b0);

`ifdef STBY_RAIL_RETRY_EN
    // Bounded retries with power-good stuck low
    begin
      int retries;
      int prev;
      retries = 0;
      prev = S_OFF;
      for (int c = 0; c < 300; c++) begin
        tick(1'b1, 1'b0);
        if (prev == S_FAULT && 32'(bus.fsm) == S_RAMP) retries++;
        prev = 32'(bus.fsm);
      end
      chk("retry_count", retries, RETRY);
      chk("retry_final_fault", 32'(bus.fault_asw), 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
